hpm_update_sched: RTL and testbench

Shared-adder update scheduler for the hardware performance counter bank in the privileged unit. Per-counter event pulses accumulate in small pending registers. A round-robin scheduler commits one pending count per cycle into the 64-bit counter storage through a single shared adder. CSR writes take priority over commits, and a drain handshake gives the CSR read path an exact snapshot.

---
 rtl/hpm_update_sched_if.sv | 28 ++
 rtl/hpm_update_sched.sv | 112 +++++++++++
 tb/tb_hpm_update_sched.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hpm_update_sched_if.sv
// hpm_update_sched_if: event, CSR access, drain and overflow signals of the HPM update scheduler.
interface hpm_update_sched_if #(
    parameter int NCNT = 32
);
    logic [NCNT-1:0] event_i;
    logic [NCNT-1:0] inhibit_i;
    logic            wr_en_i;
    logic [4:0]      wr_idx_i;
    logic [1:0]      wr_be_i;
    logic [63:0]     wr_data_i;
    logic [4:0]      rd_idx_i;
    logic [63:0]     rd_data_o;
    logic            drain_req_i;
    logic            drain_ack_o;
    logic            drain_busy_o;
    logic [NCNT-1:0] lost_o;
    logic [NCNT-1:0] ovf_clr_i;
    logic [NCNT-1:0] ovf_o;
    logic            ovf_irq_o;
    modport master (
        output event_i, inhibit_i, wr_en_i, wr_idx_i, wr_be_i, wr_data_i, rd_idx_i, drain_req_i, ovf_clr_i,
        input  rd_data_o, drain_ack_o, drain_busy_o, lost_o, ovf_o, ovf_irq_o
    );
    modport slave (
        input  event_i, inhibit_i, wr_en_i, wr_idx_i, wr_be_i, wr_data_i, rd_idx_i, drain_req_i, ovf_clr_i,
        output rd_data_o, drain_ack_o, drain_busy_o, lost_o, ovf_o, ovf_irq_o
    );
endinterface

// File: rtl/hpm_update_sched.sv
// hpm_update_sched: HPM counter bank; per-counter pending events committed round-robin through one shared adder.
// Define HPM_OVF_IRQ_EN to add sticky carry-out flags and the overflow interrupt.
module hpm_update_sched #(
    parameter int NCNT  = 32,
    parameter int PENDW = 6
) (
    input logic clk,
    input logic reset,
    hpm_update_sched_if.slave bus
);
    localparam int PW = (NCNT > 1) ? $clog2(NCNT) : 1;
`ifdef HPM_OVF_IRQ_EN
    localparam int SUMW = 65;
`else
    localparam int SUMW = 64;
`endif
    typedef enum logic {IDLE, BUSY} drainState_t;
    drainState_t drainState;
    logic [63:0] cnt [NCNT];
    logic [PENDW-1:0] pend [NCNT];
    logic [PW-1:0] ptr, sel, idx;
    logic selValid, drainAck;
    logic [NCNT-1:0] evt, nonZero, wrHit, selHit, lost, drainMask, maskLeft;
    logic [SUMW-1:0] sum;

    assign evt = bus.event_i & ~bus.inhibit_i;
    assign wrHit = bus.wr_en_i ? NCNT'(1) << bus.wr_idx_i : '0;
    assign selHit = selValid ? NCNT'(1) << sel : '0;
    assign sum = SUMW'(cnt[sel]) + SUMW'(pend[sel]);

    always_comb begin
        nonZero = '0;
        for (int i = 0; i < NCNT; i++) nonZero[i] = |pend[i];
    end

    // Scanning from the far end down lets the nearest candidate at or after ptr win.
    always_comb begin
        sel = '0;
        selValid = 1'b0;
        idx = '0;
        for (int k = NCNT - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k >= NCNT) ? int'(ptr) + k - NCNT : int'(ptr) + k);
            if (nonZero[idx] && !wrHit[idx]) begin
                sel = idx;
                selValid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCNT; i++) begin
                cnt[i] <= '0;
                pend[i] <= '0;
            end
            lost <= '0;
            ptr <= '0;
        end else begin
            for (int i = 0; i < NCNT; i++) begin
                if (wrHit[i]) begin
                    cnt[i] <= {bus.wr_be_i[1] ? bus.wr_data_i[63:32] : cnt[i][63:32],
                               bus.wr_be_i[0] ? bus.wr_data_i[31:0] : cnt[i][31:0]};
                    pend[i] <= '0;
                    lost[i] <= 1'b0;
                end else if (selHit[i]) begin
                    cnt[i] <= sum[63:0];
                    pend[i] <= PENDW'(evt[i]);
                end else if (evt[i] && &pend[i]) begin
                    lost[i] <= 1'b1;
                end else if (evt[i]) begin
                    pend[i] <= pend[i] + 1'b1;
                end
            end
            if (selValid) ptr <= (int'(sel) == NCNT - 1) ? '0 : sel + 1'b1;
        end
    end

    // Indices committed or written this cycle leave the drain mask, including in the request cycle.
    assign maskLeft = ((drainState == BUSY) ? drainMask : nonZero) & ~(wrHit | selHit);

    always_ff @(posedge clk) begin
        if (reset) begin
            drainState <= IDLE;
            drainMask <= '0;
            drainAck <= 1'b0;
        end else begin
            drainMask <= maskLeft;
            drainAck <= (drainState == BUSY || bus.drain_req_i) && maskLeft == '0;
            if (drainState == BUSY || bus.drain_req_i) drainState <= (maskLeft == '0) ? IDLE : BUSY;
        end
    end

    assign bus.drain_ack_o = drainAck;
    assign bus.drain_busy_o = drainState == BUSY;
    assign bus.lost_o = lost;
    assign bus.rd_data_o = (int'(bus.rd_idx_i) < NCNT) ? cnt[PW'(bus.rd_idx_i)] : '0;

`ifdef HPM_OVF_IRQ_EN
    logic [NCNT-1:0] ovf;
    always_ff @(posedge clk) begin
        if (reset) ovf <= '0;
        else ovf <= (ovf & ~bus.ovf_clr_i) | (sum[64] ? selHit : '0);
    end
    assign bus.ovf_o = ovf;
    assign bus.ovf_irq_o = |ovf;
`else
    logic unusedOvfClr;
    assign unusedOvfClr = ^bus.ovf_clr_i;
    assign bus.ovf_o = '0;
    assign bus.ovf_irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_hpm_update_sched.sv
// tb_hpm_update_sched: random and directed stimulus on a 32x6 and a 4x2 scheduler, checked against a counting model.
module tb_hpm_update_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] ev[2], inh[2], oclr[2], lostO[2], ovfO[2];
    logic wen[2], dreq[2], ackO[2], busyO[2], irqO[2];
    logic [4:0] widx[2], ridx[2];
    logic [1:0] wbe[2];
    logic [63:0] wdat[2], rdat[2];

    hpm_update_sched_if #(.NCNT(32)) b0 ();
    hpm_update_sched_if #(.NCNT(4)) b1 ();
    hpm_update_sched #(.NCNT(32), .PENDW(6)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    hpm_update_sched #(.NCNT(4), .PENDW(2)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    assign b0.event_i = ev[0];
    assign b0.inhibit_i = inh[0];
    assign b0.ovf_clr_i = oclr[0];
    assign b0.wr_en_i = wen[0];
    assign b0.wr_idx_i = widx[0];
    assign b0.wr_be_i = wbe[0];
    assign b0.wr_data_i = wdat[0];
    assign b0.rd_idx_i = ridx[0];
    assign b0.drain_req_i = dreq[0];
    assign b1.event_i = ev[1][3:0];
    assign b1.inhibit_i = inh[1][3:0];
    assign b1.ovf_clr_i = oclr[1][3:0];
    assign b1.wr_en_i = wen[1];
    assign b1.wr_idx_i = widx[1];
    assign b1.wr_be_i = wbe[1];
    assign b1.wr_data_i = wdat[1];
    assign b1.rd_idx_i = ridx[1];
    assign b1.drain_req_i = dreq[1];
    assign rdat[0] = b0.rd_data_o;
    assign rdat[1] = b1.rd_data_o;
    assign lostO[0] = b0.lost_o;
    assign lostO[1] = {28'd0, b1.lost_o};
    assign ovfO[0] = b0.ovf_o;
    assign ovfO[1] = {28'd0, b1.ovf_o};
    assign ackO[0] = b0.drain_ack_o;
    assign ackO[1] = b1.drain_ack_o;
    assign busyO[0] = b0.drain_busy_o;
    assign busyO[1] = b1.drain_busy_o;
    assign irqO[0] = b0.ovf_irq_o;
    assign irqO[1] = b1.ovf_irq_o;

    int nc[2] = '{32, 4};
    int pmax[2] = '{63, 3};
    logic [63:0] mCnt[2][32];
    int mPend[2][32];
    int mPtr[2];
    logic [31:0] mLost[2], mOvf[2], mMask[2];
    logic mBusy[2], mAck[2];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic modelReset(input int u);
        for (int i = 0; i < 32; i++) begin
            mCnt[u][i] = 64'd0;
            mPend[u][i] = 0;
        end
        mPtr[u] = 0;
        mLost[u] = 0;
        mOvf[u] = 0;
        mMask[u] = 0;
        mBusy[u] = 1'b0;
        mAck[u] = 1'b0;
    endtask

    // One clock of the counting rules, applied to the state before the edge.
    task automatic modelStep(input int u);
        int n, sel, w, j;
        logic [31:0] done, setOvf;
        logic [63:0] nv;
        int e;
        n = nc[u];
        sel = -1;
        w = -1;
        done = 0;
        setOvf = 0;
        if (wen[u] && int'(widx[u]) < n) w = int'(widx[u]);
        for (int k = 0; k < n; k++) begin
            j = (mPtr[u] + k) % n;
            if (sel < 0 && mPend[u][j] != 0 && j != w) sel = j;
        end
        if (sel >= 0) done |= 32'd1 << sel;
        if (w >= 0) done |= 32'd1 << w;
        mAck[u] = 1'b0;
        if (mBusy[u] || dreq[u]) begin
            if (!mBusy[u]) begin
                mMask[u] = 0;
                for (int i = 0; i < n; i++) if (mPend[u][i] != 0) mMask[u] |= 32'd1 << i;
            end
            mMask[u] &= ~done;
            mBusy[u] = mMask[u] != 0;
            mAck[u] = !mBusy[u];
        end
        for (int i = 0; i < n; i++) begin
            e = ((ev[u] & ~inh[u] & (32'd1 << i)) != 0) ? 1 : 0;
            if (i == w) begin
                mCnt[u][i] = {wbe[u][1] ? wdat[u][63:32] : mCnt[u][i][63:32],
                              wbe[u][0] ? wdat[u][31:0] : mCnt[u][i][31:0]};
                mPend[u][i] = 0;
                mLost[u] &= ~(32'd1 << i);
            end else if (i == sel) begin
                nv = mCnt[u][i] + 64'(mPend[u][i]);
                if (nv < mCnt[u][i]) setOvf |= 32'd1 << i;
                mCnt[u][i] = nv;
                mPend[u][i] = e;
            end else if (e != 0) begin
                if (mPend[u][i] == pmax[u]) mLost[u] |= 32'd1 << i;
                else mPend[u][i]++;
            end
        end
`ifdef HPM_OVF_IRQ_EN
        mOvf[u] = (mOvf[u] & ~oclr[u]) | setOvf;
`endif
        if (sel >= 0) mPtr[u] = (sel + 1) % n;
    endtask

    task automatic tick();
        @(posedge clk);
        for (int u = 0; u < 2; u++) if (reset) modelReset(u); else modelStep(u);
        #1;
        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d_rd%0d", u, ridx[u]), rdat[u], (int'(ridx[u]) < nc[u]) ? mCnt[u][ridx[u]] : 64'd0);
            check($sformatf("u%0d_lost", u), 64'(lostO[u]), 64'(mLost[u]));
            check($sformatf("u%0d_ovf", u), 64'(ovfO[u]), 64'(mOvf[u]));
            check($sformatf("u%0d_irq", u), 64'(irqO[u]), 64'(mOvf[u] != 0));
            check($sformatf("u%0d_busy", u), 64'(busyO[u]), 64'(mBusy[u]));
            check($sformatf("u%0d_ack", u), 64'(ackO[u]), 64'(mAck[u]));
        end
    endtask

    task automatic zeroIn();
        for (int u = 0; u < 2; u++) begin
            ev[u] = 0;
            inh[u] = 0;
            oclr[u] = 0;
            wen[u] = 1'b0;
            widx[u] = 0;
            wbe[u] = 0;
            wdat[u] = 0;
            ridx[u] = 0;
            dreq[u] = 1'b0;
        end
    endtask

    task automatic doReset();
        zeroIn();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic randomCycle();
        int d;
        for (int u = 0; u < 2; u++) begin
            d = $urandom_range(0, 3);
            ev[u] = (d == 0) ? 32'd0 : (d == 3) ? 32'hFFFF_FFFF : $urandom & $urandom;
            inh[u] = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
            wen[u] = $urandom_range(0, 9) == 0;
            widx[u] = (u == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wbe[u] = 2'($urandom_range(0, 3));
            wdat[u] = $urandom_range(0, 1) ? {32'hFFFF_FFFF, 32'hFFFF_FF00 | $urandom} : {$urandom, $urandom};
            dreq[u] = $urandom_range(0, 15) == 0;
            oclr[u] = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
            ridx[u] = 5'($urandom_range(0, 31));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n, li;
        zeroIn();
        tick();
        tick();
        reset = 1'b0;
        check("rst_rd0", rdat[0], 0);
        check("rst_lost", 64'(lostO[0] | lostO[1]), 0);
        check("rst_busy", 64'(busyO[0]), 0);
        check("rst_ack", 64'(ackO[0]), 0);
        check("rst_irq", 64'(irqO[0]), 0);

        ridx[0] = 2;
        ev[0] = 32'h4;
        repeat (10) tick();
        ev[0] = 0;
        repeat (2) tick();
        check("ev2_cnt", rdat[0], 64'd10);

        doReset();
        ev[0] = 32'hFFFF_FFFF;
        ev[1] = 32'hF;
        repeat (200) tick();
        ev[0] = 0;
        ev[1] = 0;
        dreq[0] = 1'b1;
        dreq[1] = 1'b1;
        tick();
        dreq[0] = 1'b0;
        dreq[1] = 1'b0;
        n = 1;
        while (!ackO[0] && n < 40) begin
            tick();
            n++;
        end
        check("drain_ack_seen", 64'(ackO[0]), 1);
        check("drain_ack_lat", 64'(n <= 33), 1);
        check("all200_lost", 64'(lostO[0]), 0);
        for (int i = 0; i < 32; i++) begin
            ridx[0] = 5'(i);
            tick();
            check($sformatf("all200_cnt%0d", i), rdat[0], 64'd200);
        end

        doReset();
        ridx[0] = 5;
        wen[0] = 1'b1;
        widx[0] = 5;
        wbe[0] = 2'b11;
        wdat[0] = 64'h1234_5678_0000_0000;
        tick();
        wen[0] = 1'b0;
        inh[0] = 32'h20;
        ev[0] = 32'h20;
        repeat (5) tick();
        check("inhibit_cnt5", rdat[0], 64'h1234_5678_0000_0000);
        inh[0] = 0;
        ev[0] = 32'hFFFF_FFFF;
        repeat (20) tick();
        wen[0] = 1'b1;
        wbe[0] = 2'b01;
        wdat[0] = 64'h0000_0000_DEAD_BEEF;
        tick();
        wen[0] = 1'b0;
        ev[0] = 0;
        check("wr_lo_cnt5", rdat[0], 64'h1234_5678_DEAD_BEEF);
        repeat (40) tick();
        check("wr_pend5_zero", rdat[0], 64'h1234_5678_DEAD_BEEF);

        doReset();
        ev[1] = 32'hF;
        repeat (12) tick();
        check("u1_lost_set", 64'(lostO[1] != 0), 1);
        li = 0;
        while (li < 3 && ((mLost[1] >> li) & 32'd1) == 0) li++;
        wen[1] = 1'b1;
        widx[1] = 5'(li);
        wbe[1] = 2'b11;
        wdat[1] = 0;
        tick();
        wen[1] = 1'b0;
        ev[1] = 0;
        check("u1_lost_clr", 64'((lostO[1] >> li) & 32'd1), 0);

        doReset();
        ridx[0] = 3;
        wen[0] = 1'b1;
        widx[0] = 3;
        wbe[0] = 2'b11;
        wdat[0] = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        wen[0] = 1'b0;
        ev[0] = 32'h8;
        repeat (3) tick();
        ev[0] = 0;
        repeat (3) tick();
        check("wrap_cnt3", rdat[0], 64'd1);
`ifdef HPM_OVF_IRQ_EN
        check("ovf3_set", 64'(ovfO[0]), 64'h8);
        check("irq_set", 64'(irqO[0]), 1);
        oclr[0] = 32'h8;
        tick();
        oclr[0] = 0;
        check("irq_clr", 64'(irqO[0]), 0);
`else
        check("ovf_off", 64'(ovfO[0]), 0);
        check("irq_off", 64'(irqO[0]), 0);
`endif

        doReset();
        repeat (1500) begin
            randomCycle();
            tick();
        end

        doReset();
        ev[0] = 32'hFFFF_FFFF;
        ev[1] = 32'hF;
        repeat (40) tick();
        ev[0] = 0;
        ev[1] = 0;
        dreq[0] = 1'b1;
        tick();
        dreq[0] = 1'b0;
        tick();
        check("mid_drain_busy", 64'(busyO[0]), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ridx[0] = 5'(i);
            tick();
            check($sformatf("post_rst_cnt%0d", i), rdat[0], 0);
            check("post_rst_no_ack", 64'(ackO[0]), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
